// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI4 read arbiter.
//   state_e     : arbiter FSM encoding (IDLE / ADDR / DATA)
//   BURST_*     : AXI burst-type encodings
//   GNT_*       : grant identifiers (0 = instruction fetch m0, 1 = data load m1)
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant picker for the AXI read arbiter.
// Build option: AXI_RD_ARB_DPRIO_EN -> fixed priority, m1 wins every tie
// (last-grant state is not kept). Undefined -> two-way round-robin.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_i[1:0]   request vector {m1, m0}
//   upd_i        pulse at the end of a transaction
//   upd_id_i     id of the master whose transaction just finished
//   gnt_valid_o  at least one request present
//   gnt_id_o     winning master id (meaningful when gnt_valid_o)
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  assign gnt_valid_o = |req_i;

`ifdef AXI_RD_ARB_DPRIO_EN
  logic unused_rr;
  assign unused_rr = ^{clk, rst, upd_i, upd_id_i};

  always_comb begin
    gnt_id_o = req_i[1] ? GNT_M1 : GNT_M0;
  end
`else
  logic last_grant_q;
  logic last_grant_d;

  // Reset to m1 so that m0 wins the very first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_M1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    last_grant_d = upd_i ? upd_id_i : last_grant_q;
  end

  always_comb begin
    gnt_id_o = GNT_M0;
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_grant_q;
    end else if (req_i[1]) begin
      gnt_id_o = GNT_M1;
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between instruction fetch (m0) and data load (m1).
// One transaction in flight; burst length checked against the observed rlast.
// Build option: AXI_RD_ARB_DPRIO_EN (see rr_arb2) selects fixed m1 priority.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   m{0,1}_ar*                       requester AR channel (arready is a 1-cycle pulse)
//   m{0,1}_r*                        routed R channel; zero when not granted
//   s_ar*                            downstream AR channel (latched fields)
//   s_r*                             downstream R channel
//   grant_id, busy, len_err          status; len_err is sticky until rst
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate and latch the winner's AR fields
// ADDR    | s_arvalid held until downstream accepts
// DATA    | R beats routed to the granted master until the rlast beat
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic [3:0]        m0_arcache,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_rlast,
  input  logic              m0_rready,

  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic [3:0]        m1_arcache,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_rlast,
  input  logic              m1_rready,

  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic [3:0]        s_arcache,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  input  logic              s_rlast,
  output logic              s_rready,

  output logic              grant_id,
  output logic              busy,
  output logic              len_err
);

  localparam logic [LEN_W:0] BEAT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_e            state_q,   state_d;
  logic              grant_q,   grant_d;
  logic [ADDR_W-1:0] araddr_q,  araddr_d;
  logic [LEN_W-1:0]  arlen_q,   arlen_d;
  logic [2:0]        arsize_q,  arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [3:0]        arcache_q, arcache_d;
  logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
  logic              len_err_q, len_err_d;

  logic arb_valid;
  logic arb_id;
  logic arb_upd;
  logic in_idle;
  logic in_data;
  logic sel_m1;
  logic r_beat;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({m1_arvalid, m0_arvalid}),
    .upd_i       (arb_upd),
    .upd_id_i    (grant_q),
    .gnt_valid_o (arb_valid),
    .gnt_id_o    (arb_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= GNT_M0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      arcache_q  <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
      arcache_q  <= arcache_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign in_idle = (state_q == ST_IDLE);
  assign in_data = (state_q == ST_DATA);
  assign sel_m1  = (grant_q == GNT_M1);
  assign r_beat  = s_rvalid & s_rready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    arcache_d  = arcache_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    arb_upd    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_ADDR;
          grant_d = arb_id;
          if (arb_id == GNT_M1) begin
            araddr_d  = m1_araddr;
            arlen_d   = m1_arlen;
            arsize_d  = m1_arsize;
            arburst_d = m1_arburst;
            arcache_d = m1_arcache;
          end else begin
            araddr_d  = m0_araddr;
            arlen_d   = m0_arlen;
            arsize_d  = m0_arsize;
            arburst_d = m0_arburst;
            arcache_d = m0_arcache;
          end
        end
      end

      ST_ADDR: begin
        if (s_arready) begin
          state_d    = ST_DATA;
          beat_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (r_beat) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          // beat_cnt_q counts beats already taken, so on the final expected
          // beat it equals arlen.
          if (s_rlast) begin
            if (beat_cnt_q != {1'b0, arlen_q}) begin
              len_err_d = 1'b1;
            end
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            arb_upd    = 1'b1;
          end else if (beat_cnt_q == {1'b0, arlen_q}) begin
            len_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // arready is combinational so the handshake completes in the IDLE cycle;
  // gated by rst so nothing is acknowledged while the block is held in reset.
  assign m0_arready = ~rst & in_idle & arb_valid & (arb_id == GNT_M0);
  assign m1_arready = ~rst & in_idle & arb_valid & (arb_id == GNT_M1);

  assign m0_rvalid = in_data & ~sel_m1 & s_rvalid;
  assign m0_rlast  = in_data & ~sel_m1 & s_rlast;
  assign m0_rdata  = (in_data & ~sel_m1) ? s_rdata : '0;
  assign m1_rvalid = in_data & sel_m1 & s_rvalid;
  assign m1_rlast  = in_data & sel_m1 & s_rlast;
  assign m1_rdata  = (in_data & sel_m1) ? s_rdata : '0;

  assign s_rready  = in_data & (sel_m1 ? m1_rready : m0_rready);
  assign s_arvalid = (state_q == ST_ADDR);
  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arsize  = arsize_q;
  assign s_arburst = arburst_q;
  assign s_arcache = arcache_q;

  assign grant_id = grant_q;
  assign busy     = ~in_idle;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

`ifdef AXI_RD_ARB_DPRIO_EN
  localparam logic DPRIO = 1'b1;
`else
  localparam logic DPRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic [3:0]  m0_arcache, m1_arcache;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic        m0_rready, m1_rready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [3:0]  s_arcache;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid, s_rlast, s_rready;
  logic        grant_id, busy, len_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arcache(m0_arcache),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arcache(m1_arcache),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arcache(s_arcache), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy), .len_err(len_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_araddr = '0; m1_araddr = '0; m0_arvalid = 0; m1_arvalid = 0;
    m0_arlen = '0; m1_arlen = '0; m0_arsize = 3'd2; m1_arsize = 3'd2;
    m0_arburst = 2'b01; m1_arburst = 2'b01; m0_arcache = 4'h3; m1_arcache = 4'h3;
    m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rdata = '0; s_rvalid = 0; s_rlast = 0;
  endtask

  // Entered in the first ADDR cycle: accept address, deliver one rlast beat,
  // return in the following IDLE cycle.
  task automatic run_single(input logic [31:0] d);
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = d;
    m0_rready = 1; m1_rready = 1;
    step();
    s_rvalid = 0; s_rlast = 0; s_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step(); step();
    vectors++;
    if ({busy, s_arvalid, s_rready, m0_arready, m1_arready, grant_id, len_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, s_arvalid, s_rready, m0_arready, m1_arready, grant_id, len_err});
    end
    vectors++;
    if (s_araddr !== 32'h0 || s_arlen !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_fields: got addr %h len %h expected 0 0", s_araddr, s_arlen);
    end
    rst = 0;
  endtask

  task automatic test_round_robin();
    logic       w;
    logic [1:0] exp_ar;
    w = DPRIO;
    m0_araddr = 32'h200; m1_araddr = 32'h300;
    m0_arvalid = 1; m1_arvalid = 1;
    #1;
    exp_ar = w ? 2'b10 : 2'b01;
    vectors++;
    if ({m1_arready, m0_arready} !== exp_ar) begin
      miscompares++;
      $display("FAIL rr_tie1: got %b expected %b", {m1_arready, m0_arready}, exp_ar);
    end
    step();
    vectors++;
    if (grant_id !== w || s_araddr !== (w ? 32'h300 : 32'h200) || s_arvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL rr_addr1: got gnt %b addr %h arv %b expected gnt %b", grant_id, s_araddr, s_arvalid, w);
    end
    if (w) m1_arvalid = 0; else m0_arvalid = 0;
    run_single(32'h11);
    #1;
    exp_ar = w ? 2'b01 : 2'b10;
    vectors++;
    if ({m1_arready, m0_arready} !== exp_ar) begin
      miscompares++;
      $display("FAIL rr_second: got %b expected %b", {m1_arready, m0_arready}, exp_ar);
    end
    step();
    vectors++;
    if (grant_id !== ~w) begin
      miscompares++;
      $display("FAIL rr_gnt2: got %b expected %b", grant_id, ~w);
    end
    m0_arvalid = 0; m1_arvalid = 0;
    run_single(32'h22);
    m0_arvalid = 1; m1_arvalid = 1;
    #1;
    exp_ar = w ? 2'b10 : 2'b01;
    vectors++;
    if ({m1_arready, m0_arready} !== exp_ar) begin
      miscompares++;
      $display("FAIL rr_tie2: got %b expected %b", {m1_arready, m0_arready}, exp_ar);
    end
    step();
    m0_arvalid = 0; m1_arvalid = 0;
    run_single(32'h33);
  endtask

  task automatic test_single_m0();
    m0_araddr = 32'h100; m0_arlen = 8'd0; m0_arvalid = 1;
    #1;
    vectors++;
    if (m0_arready !== 1'b1 || m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL m0_arready: got m0 %b m1 %b sarv %b expected 1 0 0", m0_arready, m1_arready, s_arvalid);
    end
    step();
    m0_arvalid = 0;
    vectors++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h100 || m0_arready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL m0_addr: got arv %b addr %h ar %b busy %b expected 1 100 0 1", s_arvalid, s_araddr, m0_arready, busy);
    end
    step();
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'hDEADBEEF; m0_rready = 1;
    #1;
    vectors++;
    if (m0_rdata !== 32'hDEADBEEF || m0_rvalid !== 1'b1 || m0_rlast !== 1'b1 || s_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL m0_data: got %h v %b l %b rr %b expected deadbeef 1 1 1", m0_rdata, m0_rvalid, m0_rlast, s_rready);
    end
    vectors++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL m1_quiet: got v %b d %h expected 0 0", m1_rvalid, m1_rdata);
    end
    step();
    s_rvalid = 0; s_rlast = 0; s_rdata = '0;
    vectors++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      miscompares++;
      $display("FAIL m0_done: got busy %b err %b expected 0 0", busy, len_err);
    end
  endtask

  task automatic test_burst_stall();
    logic [7:0] rv_pat, rr_pat;
    int beat, hs, m0_seen;
    rv_pat = 8'b1011_1101;
    rr_pat = 8'b1111_0011;
    beat = 0; hs = 0; m0_seen = 0;
    m1_araddr = 32'h800; m1_arlen = 8'd3; m1_arvalid = 1;
    m0_rready = 1; m1_rready = 0;
    #1;
    vectors++;
    if (m1_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_arready: got %b expected 1", m1_arready);
    end
    step();
    m1_arvalid = 0;
    s_arready = 1;
    step();
    s_arready = 0;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = rv_pat[i];
      m1_rready = rr_pat[i];
      s_rdata = 32'hA0 + beat;
      s_rlast = rv_pat[i] && (beat == 3);
      #1;
      if (m0_rvalid !== 1'b0) m0_seen++;
      vectors++;
      if (s_rready !== rr_pat[i] || m1_rvalid !== rv_pat[i]) begin
        miscompares++;
        $display("FAIL burst_route[%0d]: got rr %b rv %b expected %b %b", i, s_rready, m1_rvalid, rr_pat[i], rv_pat[i]);
      end
      if (rv_pat[i]) begin
        vectors++;
        if (m1_rdata !== 32'hA0 + beat) begin
          miscompares++;
          $display("FAIL burst_data[%0d]: got %h expected %h", i, m1_rdata, 32'hA0 + beat);
        end
      end
      if (m1_rvalid === 1'b1 && m1_rready) hs++;
      if (rv_pat[i] && rr_pat[i]) beat++;
      step();
    end
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    vectors++;
    if (hs != 4 || m0_seen != 0 || busy !== 1'b0 || len_err !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_end: got hs %0d m0v %0d busy %b err %b expected 4 0 0 0", hs, m0_seen, busy, len_err);
    end
  endtask

  task automatic test_len_err_short();
    m0_araddr = 32'h400; m0_arlen = 8'd1; m0_arvalid = 1;
    step();
    m0_arvalid = 0;
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'h1; m0_rready = 1;
    #1;
    vectors++;
    if (len_err !== 1'b0) begin
      miscompares++;
      $display("FAIL short_pre: got %b expected 0", len_err);
    end
    step();
    s_rvalid = 0; s_rlast = 0;
    vectors++;
    if (len_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL short_err: got err %b busy %b expected 1 0", len_err, busy);
    end
    m1_arlen = 8'd0; m1_araddr = 32'h410; m1_arvalid = 1;
    step();
    m1_arvalid = 0;
    run_single(32'h44);
    vectors++;
    if (len_err !== 1'b1) begin
      miscompares++;
      $display("FAIL short_sticky: got %b expected 1", len_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    m0_araddr = 32'h450; m0_arlen = 8'd3; m0_arvalid = 1;
    step();
    m0_arvalid = 0;
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1; m0_rready = 1;
    step();
    #2;
    rst = 1;
    #1;
    vectors++;
    if (busy !== 1'b0 || s_arvalid !== 1'b0 || s_rready !== 1'b0 || m0_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid: got busy %b arv %b rr %b rv %b expected 0 0 0 0", busy, s_arvalid, s_rready, m0_rvalid);
    end
    vectors++;
    if (len_err !== 1'b0 || s_araddr !== 32'h0 || grant_id !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_regs: got err %b addr %h gnt %b expected 0 0 0", len_err, s_araddr, grant_id);
    end
    step();
    s_rvalid = 0; m0_rready = 0;
    rst = 0;
    m0_araddr = 32'h500; m0_arlen = 8'd0; m0_arvalid = 1;
    #1;
    vectors++;
    if (m0_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_fresh_ar: got %b expected 1", m0_arready);
    end
    step();
    m0_arvalid = 0;
    vectors++;
    if (s_araddr !== 32'h500 || s_arlen !== 8'd0 || s_arvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_fresh_addr: got %h len %h arv %b expected 500 0 1", s_araddr, s_arlen, s_arvalid);
    end
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'h55AA; m0_rready = 1;
    #1;
    vectors++;
    if (m0_rdata !== 32'h55AA || m0_rlast !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_fresh_data: got %h l %b expected 55aa 1", m0_rdata, m0_rlast);
    end
    step();
    s_rvalid = 0; s_rlast = 0;
    vectors++;
    if (busy !== 1'b0 || len_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_fresh_done: got busy %b err %b expected 0 0", busy, len_err);
    end
  endtask

  task automatic test_missing_last();
    m0_araddr = 32'h700; m0_arlen = 8'd0; m0_arvalid = 1;
    step();
    m0_arvalid = 0;
    s_arready = 1;
    step();
    s_arready = 0;
    s_rvalid = 1; s_rlast = 0; m0_rready = 1;
    step();
    vectors++;
    if (len_err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL nolast_err: got err %b busy %b expected 1 1", len_err, busy);
    end
    s_rlast = 1;
    step();
    s_rvalid = 0; s_rlast = 0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nolast_end: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_addr_stall();
    int pulses;
    pulses = 0;
    m1_araddr = 32'h600; m1_arlen = 8'd0; m1_arvalid = 1;
    step();
    m0_araddr = 32'h610; m0_arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0) pulses++;
      vectors++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h600 || grant_id !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got arv %b addr %h gnt %b expected 1 600 1", i, s_arvalid, s_araddr, grant_id);
      end
      step();
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL stall_pulses: got %0d expected 0", pulses);
    end
    m1_arvalid = 0;
    run_single(32'h66);
    #1;
    vectors++;
    if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_waiter: got m0 %b m1 %b expected 1 0", m0_arready, m1_arready);
    end
    step();
    m0_arvalid = 0;
    vectors++;
    if (s_araddr !== 32'h610 || grant_id !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_next: got %h gnt %b expected 610 0", s_araddr, grant_id);
    end
    run_single(32'h77);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_m0();
    test_burst_stall();
    test_len_err_short();
    test_reset_mid_burst();
    test_missing_last();
    test_addr_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
